// File: rtl/muldiv_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// muldiv_ctrl_if : CPU request, multiplier/divider unit and HI/LO bundle
// Revision 1.0
// ---------------------------------------------------------------------------
interface muldiv_ctrl_if;
   logic        op_valid;
   logic [2:0]  op_code;
   logic [31:0] rs_data;
   logic [31:0] rt_data;
   logic        op_ready;

   logic        mult_start;
   logic [31:0] mult_a;
   logic [31:0] mult_b;
   logic [31:0] mult_hi;
   logic [31:0] mult_lo;
   logic        mult_done;

   logic        div_start;
   logic [31:0] div_a;
   logic [31:0] div_b;
   logic [31:0] div_hi;
   logic [31:0] div_lo;
   logic        div_done;

   logic [31:0] hi_q;
   logic [31:0] lo_q;
   logic [31:0] result;
   logic        result_valid;
   logic        op_done;
   logic        div_zero;
   logic        timeout;

   modport slave (
      input  op_valid, op_code, rs_data, rt_data,
      input  mult_hi, mult_lo, mult_done, div_hi, div_lo, div_done,
      output op_ready, mult_start, mult_a, mult_b, div_start, div_a, div_b,
      output hi_q, lo_q, result, result_valid, op_done, div_zero, timeout
   );

   modport master (
      output op_valid, op_code, rs_data, rt_data,
      output mult_hi, mult_lo, mult_done, div_hi, div_lo, div_done,
      input  op_ready, mult_start, mult_a, mult_b, div_start, div_a, div_b,
      input  hi_q, lo_q, result, result_valid, op_done, div_zero, timeout
   );
endinterface
`default_nettype wire

// File: rtl/muldiv_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// muldiv_ctrl : HI/LO sequencer for external multiplier and divider units
// Revision 1.0
// ---------------------------------------------------------------------------
module muldiv_ctrl #(
   parameter int unsigned TIMEOUT = 40
) (
   input  logic          clk,
   input  logic          reset,
   muldiv_ctrl_if.slave  bus
);

   localparam logic [2:0] C_OP_MULT = 3'b001;
   localparam logic [2:0] C_OP_DIV  = 3'b010;
   localparam logic [2:0] C_OP_MFHI = 3'b011;
   localparam logic [2:0] C_OP_MFLO = 3'b100;
   localparam logic [2:0] C_OP_MTHI = 3'b101;
   localparam logic [2:0] C_OP_MTLO = 3'b110;
   localparam logic [5:0] C_TIMEOUT = 6'(TIMEOUT);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      M_START = 3'd1,
      M_WAIT  = 3'd2,
      D_START = 3'd3,
      D_WAIT  = 3'd4,
      DONE    = 3'd5
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] hi_q, hi_d, lo_q, lo_d;
   logic [31:0] result_q, result_d;
   logic        result_valid_q, result_valid_d;
   logic [31:0] mult_a_q, mult_a_d, mult_b_q, mult_b_d;
   logic [31:0] div_a_q, div_a_d, div_b_q, div_b_d;
   logic        div_zero_q, div_zero_d;
   logic        timeout_q, timeout_d;
   logic [5:0]  cnt_q, cnt_d;
   logic [5:0]  w_cnt_inc;

   assign w_cnt_inc = cnt_q + 6'd1;

   always_comb begin
      state_d        = state_q;
      hi_d           = hi_q;
      lo_d           = lo_q;
      result_d       = result_q;
      result_valid_d = 1'b0;
      mult_a_d       = mult_a_q;
      mult_b_d       = mult_b_q;
      div_a_d        = div_a_q;
      div_b_d        = div_b_q;
      div_zero_d     = div_zero_q;
      timeout_d      = timeout_q;
      cnt_d          = cnt_q;

      case (state_q)
         IDLE: begin
            if (bus.op_valid) begin
               case (bus.op_code)
                  C_OP_MULT: begin
                     mult_a_d   = bus.rs_data;
                     mult_b_d   = bus.rt_data;
                     div_zero_d = 1'b0;
                     timeout_d  = 1'b0;
                     state_d    = M_START;
                  end
                  C_OP_DIV: begin
                     div_a_d    = bus.rs_data;
                     div_b_d    = bus.rt_data;
                     div_zero_d = 1'b0;
                     timeout_d  = 1'b0;
                     // A zero divisor never reaches the divider unit
                     if (bus.rt_data == 32'd0) begin
                        div_zero_d = 1'b1;
                        state_d    = DONE;
                     end else begin
                        state_d    = D_START;
                     end
                  end
                  C_OP_MFHI: begin
                     result_d       = hi_q;
                     result_valid_d = 1'b1;
                  end
                  C_OP_MFLO: begin
                     result_d       = lo_q;
                     result_valid_d = 1'b1;
                  end
                  C_OP_MTHI: hi_d = bus.rs_data;
                  C_OP_MTLO: lo_d = bus.rs_data;
                  default: ;
               endcase
            end
         end
         M_START: begin
            cnt_d   = 6'd0;
            state_d = M_WAIT;
         end
         D_START: begin
            cnt_d   = 6'd0;
            state_d = D_WAIT;
         end
         M_WAIT: begin
            cnt_d = w_cnt_inc;
            if (bus.mult_done) begin
               hi_d    = bus.mult_hi;
               lo_d    = bus.mult_lo;
               state_d = DONE;
            end else if (w_cnt_inc == C_TIMEOUT) begin
               timeout_d = 1'b1;
               state_d   = DONE;
            end
         end
         D_WAIT: begin
            cnt_d = w_cnt_inc;
            if (bus.div_done) begin
               hi_d    = bus.div_hi;
               lo_d    = bus.div_lo;
               state_d = DONE;
            end else if (w_cnt_inc == C_TIMEOUT) begin
               timeout_d = 1'b1;
               state_d   = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q        <= IDLE;
         hi_q           <= 32'd0;
         lo_q           <= 32'd0;
         result_q       <= 32'd0;
         result_valid_q <= 1'b0;
         mult_a_q       <= 32'd0;
         mult_b_q       <= 32'd0;
         div_a_q        <= 32'd0;
         div_b_q        <= 32'd0;
         div_zero_q     <= 1'b0;
         timeout_q      <= 1'b0;
         cnt_q          <= 6'd0;
      end else begin
         state_q        <= state_d;
         hi_q           <= hi_d;
         lo_q           <= lo_d;
         result_q       <= result_d;
         result_valid_q <= result_valid_d;
         mult_a_q       <= mult_a_d;
         mult_b_q       <= mult_b_d;
         div_a_q        <= div_a_d;
         div_b_q        <= div_b_d;
         div_zero_q     <= div_zero_d;
         timeout_q      <= timeout_d;
         cnt_q          <= cnt_d;
      end
   end

   // Strobes decode straight from state so each lasts exactly one state cycle
   assign bus.op_ready     = (state_q == IDLE);
   assign bus.mult_start   = (state_q == M_START);
   assign bus.div_start    = (state_q == D_START);
   assign bus.op_done      = (state_q == DONE);
   assign bus.mult_a       = mult_a_q;
   assign bus.mult_b       = mult_b_q;
   assign bus.div_a        = div_a_q;
   assign bus.div_b        = div_b_q;
   assign bus.hi_q         = hi_q;
   assign bus.lo_q         = lo_q;
   assign bus.result       = result_q;
   assign bus.result_valid = result_valid_q;
   assign bus.div_zero     = div_zero_q;
   assign bus.timeout      = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_muldiv_ctrl : randomized transaction-level check of muldiv_ctrl
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_muldiv_ctrl;

   localparam int         TMO     = 40;
   localparam logic [2:0] OP_MULT = 3'b001;
   localparam logic [2:0] OP_DIV  = 3'b010;
   localparam logic [2:0] OP_MFHI = 3'b011;
   localparam logic [2:0] OP_MFLO = 3'b100;
   localparam logic [2:0] OP_MTHI = 3'b101;
   localparam logic [2:0] OP_MTLO = 3'b110;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   muldiv_ctrl_if bus ();

   muldiv_ctrl #(.TIMEOUT(TMO)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] m_hi, m_lo;
   logic        m_dz, m_to;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_ready"}, bus.op_ready, 1);
      check_eq({tag, "_hi"}, bus.hi_q, 0);
      check_eq({tag, "_lo"}, bus.lo_q, 0);
      check_eq({tag, "_result"}, bus.result, 0);
      check_eq({tag, "_rvalid"}, bus.result_valid, 0);
      check_eq({tag, "_opdone"}, bus.op_done, 0);
      check_eq({tag, "_starts"}, {bus.mult_start, bus.div_start}, 0);
      check_eq({tag, "_operands"}, {bus.mult_a, bus.mult_b, bus.div_a, bus.div_b} == 128'd0, 1);
      check_eq({tag, "_flags"}, {bus.div_zero, bus.timeout}, 0);
   endtask

   // One complete request: model the architectural result, play both units, compare
   task automatic exec_op(input logic [2:0] code, input logic [31:0] rs, input logic [31:0] rt,
                          input int delay, input logic [2:0] pcode);
      bit          is_mul, is_div, long_op, is_mf;
      int          e, exp_done_j, last_j, done_j, rv_j, n_ms, n_ds, n_od, n_rv;
      logic [31:0] exp_hi, exp_lo, exp_res, rv_data;
      logic        exp_dz, exp_to;
      logic signed [31:0] sa, sb;
      logic [63:0] prod;
      logic [31:0] quo, rem;

      is_mul  = (code == OP_MULT);
      is_div  = (code == OP_DIV) && (rt != 0);
      long_op = is_mul || is_div;
      is_mf   = (code == OP_MFHI) || (code == OP_MFLO);
      e       = (delay < TMO) ? delay : TMO;
      sa      = rs;
      sb      = rt;
      prod    = 64'(longint'(sa) * longint'(sb));
      quo     = (rt != 0) ? 32'(sa / sb) : 32'd0;
      rem     = (rt != 0) ? 32'(sa % sb) : 32'd0;
      exp_hi  = m_hi; exp_lo = m_lo; exp_dz = m_dz; exp_to = m_to;
      exp_res = (code == OP_MFHI) ? m_hi : m_lo;

      case (code)
         OP_MULT: begin
            exp_dz = 1'b0; exp_to = (delay > TMO);
            if (delay <= TMO) begin exp_hi = prod[63:32]; exp_lo = prod[31:0]; end
         end
         OP_DIV: begin
            exp_dz = (rt == 0); exp_to = (rt != 0) && (delay > TMO);
            if (rt != 0 && delay <= TMO) begin exp_hi = rem; exp_lo = quo; end
         end
         OP_MTHI: exp_hi = rs;
         OP_MTLO: exp_lo = rs;
         default: ;
      endcase
      exp_done_j = long_op ? 2 + e : ((code == OP_DIV) ? 1 : 0);
      last_j     = ((exp_done_j > 0) ? exp_done_j : 1) + 1;

      @(negedge clk);
      check_eq("ready_pre", bus.op_ready, 1);
      bus.op_valid = 1'b1;
      bus.op_code  = code;
      bus.rs_data  = rs;
      bus.rt_data  = rt;
      done_j = 0; rv_j = 0; n_ms = 0; n_ds = 0; n_od = 0; n_rv = 0; rv_data = 32'd0;

      for (int j = 1; j <= last_j; j++) begin
         @(negedge clk);
         check_eq("start_excl", bus.mult_start & bus.div_start, 0);
         check_eq("ready", bus.op_ready, (exp_done_j == 0) || (j > exp_done_j));
         if (bus.mult_start) begin
            n_ms++;
            check_eq("mult_ab", {bus.mult_a, bus.mult_b}, {rs, rt});
         end
         if (bus.div_start) begin
            n_ds++;
            check_eq("div_ab", {bus.div_a, bus.div_b}, {rs, rt});
         end
         if (bus.op_done) begin
            n_od++;
            if (done_j == 0) done_j = j;
         end
         if (bus.result_valid) begin
            n_rv++;
            rv_j    = j;
            rv_data = bus.result;
         end
         // Requests while busy must be ignored
         bus.op_valid = (pcode != 3'b000) && long_op && (j <= 1 + e);
         bus.op_code  = pcode;
         bus.rs_data  = $urandom();
         bus.mult_done = is_mul ? ((j == 1) ? 1'($urandom_range(0, 1)) : (j - 1 == delay))
                                : 1'($urandom_range(0, 1));
         bus.div_done  = is_div ? ((j == 1) ? 1'($urandom_range(0, 1)) : (j - 1 == delay))
                                : 1'($urandom_range(0, 1));
         bus.mult_hi = (is_mul && j - 1 == delay) ? prod[63:32] : $urandom();
         bus.mult_lo = (is_mul && j - 1 == delay) ? prod[31:0]  : $urandom();
         bus.div_hi  = (is_div && j - 1 == delay) ? rem : $urandom();
         bus.div_lo  = (is_div && j - 1 == delay) ? quo : $urandom();
      end
      bus.op_valid = 1'b0;

      check_eq("mult_start_cnt", n_ms, is_mul);
      check_eq("div_start_cnt", n_ds, is_div);
      check_eq("op_done_cnt", n_od, exp_done_j != 0);
      check_eq("op_done_cycle", done_j, exp_done_j);
      check_eq("rvalid_cnt", n_rv, is_mf);
      if (is_mf) begin
         check_eq("rvalid_cycle", rv_j, 1);
         check_eq("result", rv_data, exp_res);
      end
      check_eq("hi", bus.hi_q, exp_hi);
      check_eq("lo", bus.lo_q, exp_lo);
      check_eq("div_zero", bus.div_zero, exp_dz);
      check_eq("timeout", bus.timeout, exp_to);
      m_hi = exp_hi; m_lo = exp_lo; m_dz = exp_dz; m_to = exp_to;
   endtask

   initial begin
      logic [2:0]  codes [8];
      logic [2:0]  pcodes [4];
      logic [2:0]  c;
      logic [31:0] a, b;

      codes  = '{OP_MULT, OP_DIV, OP_MFHI, OP_MFLO, OP_MTHI, OP_MTLO, 3'b000, 3'b111};
      pcodes = '{3'b000, OP_MFLO, OP_MTLO, OP_MFHI};
      bus.op_valid = 1'b0; bus.op_code = 3'b000; bus.rs_data = '0; bus.rt_data = '0;
      bus.mult_hi = '0; bus.mult_lo = '0; bus.mult_done = 1'b0;
      bus.div_hi  = '0; bus.div_lo  = '0; bus.div_done  = 1'b0;
      m_hi = '0; m_lo = '0; m_dz = 1'b0; m_to = 1'b0;

      reset = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_outputs("rst");
      reset = 1'b1;

      exec_op(OP_MTHI, 32'hDEADBEEF, 32'd0, 1, 3'b000);
      exec_op(OP_MFHI, 32'd0, 32'd0, 1, 3'b000);
      exec_op(OP_MULT, 32'd7, 32'hFFFFFFFD, 33, OP_MFLO);
      exec_op(OP_DIV, 32'd100, 32'd7, 20, OP_MTLO);
      exec_op(OP_DIV, 32'd5, 32'd0, 1, 3'b000);
      exec_op(OP_MULT, 32'd3, 32'd9, 1000, 3'b000);
      exec_op(OP_MULT, 32'h12345678, 32'h9ABCDEF0, TMO, 3'b000);
      exec_op(OP_DIV, 32'hFFFFFF00, 32'd3, TMO + 1, 3'b000);
      exec_op(OP_MFLO, 32'd0, 32'd0, 1, 3'b000);
      exec_op(3'b000, 32'h11111111, 32'd1, 1, 3'b000);
      exec_op(3'b111, 32'h22222222, 32'd1, 1, 3'b000);

      for (int i = 0; i < 40; i++) begin
         c = codes[$urandom_range(0, 7)];
         a = $urandom();
         b = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom();
         if (a == 32'h80000000 && b == 32'hFFFFFFFF) b = 32'd1;
         exec_op(c, a, b, $urandom_range(1, TMO + 3), pcodes[$urandom_range(0, 3)]);
      end

      // Abort in M_WAIT: a late mult_done must not reach HI/LO
      exec_op(OP_MTHI, 32'hCAFEF00D, 32'd0, 1, 3'b000);
      @(negedge clk);
      bus.op_valid = 1'b1; bus.op_code = OP_MULT; bus.rs_data = 32'd5; bus.rt_data = 32'd6;
      @(negedge clk);
      bus.op_valid = 1'b0;
      repeat (4) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      bus.mult_done = 1'b1; bus.mult_hi = 32'hAAAA5555; bus.mult_lo = 32'h5555AAAA;
      @(negedge clk);
      check_reset_outputs("abort");
      bus.mult_done = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_outputs("abort_late");
      m_hi = '0; m_lo = '0; m_dz = 1'b0; m_to = 1'b0;
      exec_op(OP_MFHI, 32'd0, 32'd0, 1, 3'b000);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
